// File: rtl/lcd_pkg.sv
// lcd_pkg: shared FSM states, command word fields, timing defaults and the init ROM for lcd_ctrl
package lcd_pkg;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_SETUP = 3'd1;
  localparam state_t ST_PULSE = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_WAIT  = 3'd4;
  localparam state_t ST_PWRUP = 3'd5;
  localparam state_t ST_INIT  = 3'd6;
  localparam int ON_BIT   = 31;
  localparam int REQ_BIT  = 11;
  localparam int RS_BIT   = 9;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;
  localparam int T_SETUP_DEF = 2;
  localparam int T_EN_DEF    = 12;
  localparam int T_HOLD_DEF  = 1;
  localparam int T_EXEC_DEF  = 1850;
  localparam int T_CLEAR_DEF = 76000;
  localparam int T_PWRUP_DEF = 750000;
  localparam int INIT_LEN = 6;
  localparam logic [7:0] INIT_ROM [INIT_LEN] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  function automatic logic is_clear(input logic rs, input logic [7:0] data);
    return !rs && (data == 8'h01 || data == 8'h02);
  endfunction
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/lcd_if.sv
// lcd_if: LSU command/status word plus the HD44780 pin bundle driven by lcd_ctrl
interface lcd_if;
  logic [31:0] cmd;
  logic [31:0] status;
  logic        busy;
  logic        lcd_on;
  logic        lcd_en;
  logic        lcd_rs;
  logic        lcd_rw;
  logic [7:0]  lcd_data;
  modport master (output cmd, input status, busy, lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data);
  modport slave  (input cmd, output status, busy, lcd_on, lcd_en, lcd_rs, lcd_rw, lcd_data);
endinterface

// File: rtl/lcd_timer.sv
// lcd_timer: loadable down-counter that parks at zero and flags it
module lcd_timer #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;
  // a load overrides counting; the count holds once it reaches zero
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= RST_VAL;
    else if (load_i) cnt_q <= value_i;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns toggle-handshake LSU requests into timed HD44780 writes; LCD_INIT_EN adds power-up wait and init sequence
module lcd_ctrl import lcd_pkg::*; #(
  parameter int T_SETUP_CYC = T_SETUP_DEF,
  parameter int T_EN_CYC    = T_EN_DEF,
  parameter int T_HOLD_CYC  = T_HOLD_DEF,
  parameter int T_EXEC_CYC  = T_EXEC_DEF,
`ifdef LCD_INIT_EN
  parameter int T_PWRUP_CYC = T_PWRUP_DEF,
`endif
  parameter int T_CLEAR_CYC = T_CLEAR_DEF
) (
  input logic  clk_i,
  input logic  rst_ni,
  lcd_if.slave bus
);
  localparam int T_OP_MAX = max2(max2(max2(T_SETUP_CYC, T_EN_CYC), max2(T_HOLD_CYC, T_EXEC_CYC)), T_CLEAR_CYC);
`ifdef LCD_INIT_EN
  localparam int T_MAX = max2(T_OP_MAX, T_PWRUP_CYC);
`else
  localparam int T_MAX = T_OP_MAX;
`endif
  localparam int TW = $clog2(T_MAX + 1);
`ifdef LCD_INIT_EN
  localparam logic [TW-1:0] TMR_RST = TW'(T_PWRUP_CYC - 1);
  localparam logic BUSY_RST = 1'b1;
  localparam state_t ST_RST = ST_PWRUP;
  logic init_q;
  logic [2:0] idx_q;
`else
  localparam logic [TW-1:0] TMR_RST = '0;
  localparam logic BUSY_RST = 1'b0;
  localparam state_t ST_RST = ST_IDLE;
`endif
  state_t state_q;
  logic ack_q, busy_q, en_q, rs_q, on_q, ld, zero, pending;
  logic [7:0] data_q;
  logic [TW-1:0] val;
  logic unused_cmd;
  assign pending = bus.cmd[REQ_BIT] != ack_q;
  assign unused_cmd = ^{bus.cmd[30:12], bus.cmd[10], bus.cmd[8]};
  lcd_timer #(.W(TW), .RST_VAL(TMR_RST)) u_timer (
    .clk_i(clk_i), .rst_ni(rst_ni), .load_i(ld), .value_i(val), .zero_o(zero)
  );
  // reload the timer with the next state's length minus one whenever a timed state is entered
  always_comb begin
    ld = 1'b0;
    val = '0;
    case (state_q)
      ST_IDLE:  begin ld = pending; val = TW'(T_SETUP_CYC - 1); end
      ST_SETUP: begin ld = zero; val = TW'(T_EN_CYC - 1); end
      ST_PULSE: begin ld = zero; val = TW'(T_HOLD_CYC - 1); end
      ST_HOLD:  begin ld = zero; val = is_clear(rs_q, data_q) ? TW'(T_CLEAR_CYC - 1) : TW'(T_EXEC_CYC - 1); end
      ST_INIT:  begin ld = 1'b1; val = TW'(T_SETUP_CYC - 1); end
      default:  ;
    endcase
  end
  // write sequencer: accept, setup, enable pulse, hold, execution wait, then acknowledge
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q <= ST_RST;
      ack_q <= 1'b0;
      busy_q <= BUSY_RST;
      en_q <= 1'b0;
      rs_q <= 1'b0;
      data_q <= '0;
`ifdef LCD_INIT_EN
      init_q <= 1'b1;
      idx_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: if (pending) begin
          state_q <= ST_SETUP;
          busy_q <= 1'b1;
          rs_q <= bus.cmd[RS_BIT];
          data_q <= bus.cmd[DATA_MSB:DATA_LSB];
        end
        ST_SETUP: if (zero) begin
          state_q <= ST_PULSE;
          en_q <= 1'b1;
        end
        ST_PULSE: if (zero) begin
          state_q <= ST_HOLD;
          en_q <= 1'b0;
        end
        ST_HOLD: if (zero) state_q <= ST_WAIT;
        ST_WAIT: if (zero) begin
`ifdef LCD_INIT_EN
          if (init_q) begin
            if (idx_q == 3'(INIT_LEN - 1)) begin
              init_q <= 1'b0;
              busy_q <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              idx_q <= idx_q + 1'b1;
              state_q <= ST_INIT;
            end
          end else begin
            ack_q <= ~ack_q;
            busy_q <= 1'b0;
            state_q <= ST_IDLE;
          end
`else
          ack_q <= ~ack_q;
          busy_q <= 1'b0;
          state_q <= ST_IDLE;
`endif
        end
`ifdef LCD_INIT_EN
        ST_PWRUP: if (zero) state_q <= ST_INIT;
        ST_INIT: begin
          state_q <= ST_SETUP;
          rs_q <= 1'b0;
          data_q <= INIT_ROM[idx_q];
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  // power/backlight follows the command word with one register stage, outside the sequencer
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) on_q <= 1'b0;
    else on_q <= bus.cmd[ON_BIT];
  assign bus.busy = busy_q;
  assign bus.status = {30'b0, ack_q, busy_q};
  assign bus.lcd_on = on_q;
  assign bus.lcd_en = en_q;
  assign bus.lcd_rs = rs_q;
  assign bus.lcd_rw = 1'b0;
  assign bus.lcd_data = data_q;
endmodule
